// File: rtl/lc3b_mem_arbiter.sv
// rtl/lc3b_mem_arbiter.sv - two-requester (imem/dmem) arbiter onto one line-wide memory bus
// Optional round-robin arbitration selected by defining ARB_RR_EN (default: fixed dmem > imem).
module lc3b_mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 128,
   parameter int SEL_W  = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              imem_stb,
   input  logic              imem_cyc,
   input  logic              imem_we,
   input  logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_wdata,
   input  logic [SEL_W-1:0]  imem_sel,
   output logic              imem_ack,
   output logic [DATA_W-1:0] imem_rdata,
   input  logic              dmem_stb,
   input  logic              dmem_cyc,
   input  logic              dmem_we,
   input  logic [ADDR_W-1:0] dmem_addr,
   input  logic [DATA_W-1:0] dmem_wdata,
   input  logic [SEL_W-1:0]  dmem_sel,
   output logic              dmem_ack,
   output logic [DATA_W-1:0] dmem_rdata,
   output logic              mem_stb,
   output logic              mem_cyc,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [SEL_W-1:0]  mem_sel,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              grant_d
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   mem_stb_q, mem_stb_d;
   logic   grant_d_q, grant_d_d;
   logic   imem_pend, dmem_pend;
   logic   pick_d;

   assign imem_pend = imem_stb & imem_cyc;
   assign dmem_pend = dmem_stb & dmem_cyc;

`ifdef ARB_RR_EN
   // last_grant_q: 1 = dmem was granted most recently, 0 = imem
   logic last_grant_q, last_grant_d;

   always_comb begin
      pick_d       = dmem_pend & (~imem_pend | ~last_grant_q);
      last_grant_d = last_grant_q;
      if ((state_q == IDLE) && (state_d != IDLE)) begin
         last_grant_d = (state_d == SERVE_D);
      end
   end
`else
   always_comb begin
      pick_d = dmem_pend;
   end
`endif

   // The bus cycle is never aborted: only mem_ack (or reset) leaves a SERVE state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (pick_d) begin
               state_d = SERVE_D;
            end else if (imem_pend) begin
               state_d = SERVE_I;
            end
         end
         SERVE_I: if (mem_ack) state_d = IDLE;
         SERVE_D: if (mem_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      mem_stb_d = (state_d != IDLE);
      grant_d_d = (state_d == SERVE_D);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         mem_stb_q <= 1'b0;
         grant_d_q <= 1'b0;
`ifdef ARB_RR_EN
         last_grant_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         mem_stb_q <= mem_stb_d;
         grant_d_q <= grant_d_d;
`ifdef ARB_RR_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_sel   = '0;
      case (state_q)
         SERVE_I: begin
            mem_we    = imem_we;
            mem_addr  = imem_addr;
            mem_wdata = imem_wdata;
            mem_sel   = imem_sel;
         end
         SERVE_D: begin
            mem_we    = dmem_we;
            mem_addr  = dmem_addr;
            mem_wdata = dmem_wdata;
            mem_sel   = dmem_sel;
         end
         default: ;
      endcase
   end

   assign mem_stb    = mem_stb_q;
   assign mem_cyc    = mem_stb_q;
   assign grant_d    = grant_d_q;
   // A requester that dropped cyc (flush) still owns the bus but gets no ack.
   assign imem_ack   = mem_ack & (state_q == SERVE_I) & imem_cyc;
   assign dmem_ack   = mem_ack & (state_q == SERVE_D) & dmem_cyc;
   assign imem_rdata = mem_rdata;
   assign dmem_rdata = mem_rdata;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// tb/tb_lc3b_mem_arbiter.sv - directed vector bench for lc3b_mem_arbiter
module tb_lc3b_mem_arbiter;

   localparam logic [127:0] IW = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam logic [127:0] DW = 128'hD1D2_D3D4_D5D6_D7D8_D9DA_DBDC_DDDE_DFE0;
   localparam logic [127:0] RD = 128'hCAFE_F00D_0123_4567_89AB_CDEF_FEED_BEEF;

   logic         clk = 1'b0;
   logic         rst;
   logic         imem_stb, imem_cyc, imem_we, imem_ack;
   logic [15:0]  imem_addr, imem_sel;
   logic [127:0] imem_wdata, imem_rdata;
   logic         dmem_stb, dmem_cyc, dmem_we, dmem_ack;
   logic [15:0]  dmem_addr, dmem_sel;
   logic [127:0] dmem_wdata, dmem_rdata;
   logic         mem_stb, mem_cyc, mem_we, mem_ack, grant_d;
   logic [15:0]  mem_addr, mem_sel;
   logic [127:0] mem_wdata, mem_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   lc3b_mem_arbiter dut (
      .clk(clk), .rst(rst),
      .imem_stb(imem_stb), .imem_cyc(imem_cyc), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_sel(imem_sel),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .dmem_stb(dmem_stb), .dmem_cyc(dmem_cyc), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_sel(dmem_sel),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .mem_stb(mem_stb), .mem_cyc(mem_cyc), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sel(mem_sel),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .grant_d(grant_d)
   );

   typedef struct {
      logic        rst, is, ic, ds, dc, dw, ack;
      logic [15:0] ia, da, dsel;
      logic        e_stb, e_we;
      logic [15:0] e_addr, e_sel;
      logic [1:0]  e_wd;
      logic        e_iack, e_dack, e_gd;
   } vec_t;

   vec_t vecs[$];

   task automatic av(input logic r, input logic is, input logic ic, input logic [15:0] ia,
                     input logic ds, input logic dc, input logic dw, input logic [15:0] da,
                     input logic [15:0] dsel, input logic ack,
                     input logic e_stb, input logic e_we, input logic [15:0] e_addr,
                     input logic [15:0] e_sel, input logic [1:0] e_wd,
                     input logic e_iack, input logic e_dack, input logic e_gd);
      vec_t v;
      v.rst = r; v.is = is; v.ic = ic; v.ia = ia;
      v.ds = ds; v.dc = dc; v.dw = dw; v.da = da; v.dsel = dsel; v.ack = ack;
      v.e_stb = e_stb; v.e_we = e_we; v.e_addr = e_addr; v.e_sel = e_sel;
      v.e_wd = e_wd; v.e_iack = e_iack; v.e_dack = e_dack; v.e_gd = e_gd;
      vecs.push_back(v);
   endtask

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      imem_stb = 1'b0; imem_cyc = 1'b0; imem_addr = '0;
      dmem_stb = 1'b0; dmem_cyc = 1'b0; dmem_we = 1'b0; dmem_addr = '0; dmem_sel = '0;
      mem_ack  = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      logic [127:0] wd_exp;
      logic         exp_d;
      imem_we    = 1'b0;
      imem_sel   = 16'hFFFF;
      imem_wdata = IW;
      dmem_wdata = DW;
      mem_rdata  = RD;

      // rst  is ic ia       ds dc dw da       dsel     ack | stb we addr     sel      wd iack dack gd
      // stray ack in IDLE, then idle
      av(0, 0,0,16'h0000, 0,0,0,16'h0000,16'h0000, 1,  0,0,16'h0000,16'h0000,0, 0,0,0);
      av(0, 0,0,16'h0000, 0,0,0,16'h0000,16'h0000, 0,  0,0,16'h0000,16'h0000,0, 0,0,0);
      // imem read, ack three cycles after stb
      av(0, 1,1,16'h0040, 0,0,0,16'h0000,16'h0000, 0,  0,0,16'h0000,16'h0000,0, 0,0,0);
      av(0, 1,1,16'h0040, 0,0,0,16'h0000,16'h0000, 0,  1,0,16'h0040,16'hFFFF,1, 0,0,0);
      av(0, 1,1,16'h0040, 0,0,0,16'h0000,16'h0000, 0,  1,0,16'h0040,16'hFFFF,1, 0,0,0);
      av(0, 1,1,16'h0040, 0,0,0,16'h0000,16'h0000, 0,  1,0,16'h0040,16'hFFFF,1, 0,0,0);
      av(0, 1,1,16'h0040, 0,0,0,16'h0000,16'h0000, 1,  1,0,16'h0040,16'hFFFF,1, 1,0,0);
      av(0, 0,0,16'h0040, 0,0,0,16'h0000,16'h0000, 0,  0,0,16'h0000,16'h0000,0, 0,0,0);
      // dmem write
      av(0, 0,0,16'h0000, 1,1,1,16'h1234,16'h0030, 0,  0,0,16'h0000,16'h0000,0, 0,0,0);
      av(0, 0,0,16'h0000, 1,1,1,16'h1234,16'h0030, 0,  1,1,16'h1234,16'h0030,2, 0,0,1);
      av(0, 0,0,16'h0000, 1,1,1,16'h1234,16'h0030, 1,  1,1,16'h1234,16'h0030,2, 0,1,1);
      av(0, 0,0,16'h0000, 0,0,0,16'h1234,16'h0030, 0,  0,0,16'h0000,16'h0000,0, 0,0,0);
      // reset, then both pending: dmem first, bubble, imem
      av(1, 0,0,16'h0000, 0,0,0,16'h0000,16'h0000, 0,  0,0,16'h0000,16'h0000,0, 0,0,0);
      av(0, 1,1,16'h0040, 1,1,0,16'h2000,16'hFFFF, 0,  0,0,16'h0000,16'h0000,0, 0,0,0);
      av(0, 1,1,16'h0040, 1,1,0,16'h2000,16'hFFFF, 0,  1,0,16'h2000,16'hFFFF,2, 0,0,1);
      av(0, 1,1,16'h0040, 1,1,0,16'h2000,16'hFFFF, 1,  1,0,16'h2000,16'hFFFF,2, 0,1,1);
      av(0, 1,1,16'h0040, 0,0,0,16'h0000,16'h0000, 0,  0,0,16'h0000,16'h0000,0, 0,0,0);
      av(0, 1,1,16'h0040, 0,0,0,16'h0000,16'h0000, 0,  1,0,16'h0040,16'hFFFF,1, 0,0,0);
      av(0, 1,1,16'h0040, 0,0,0,16'h0000,16'h0000, 1,  1,0,16'h0040,16'hFFFF,1, 1,0,0);
      av(0, 0,0,16'h0000, 0,0,0,16'h0000,16'h0000, 0,  0,0,16'h0000,16'h0000,0, 0,0,0);
      // reset during SERVE_I, stray ack afterwards
      av(0, 1,1,16'h0080, 0,0,0,16'h0000,16'h0000, 0,  0,0,16'h0000,16'h0000,0, 0,0,0);
      av(0, 1,1,16'h0080, 0,0,0,16'h0000,16'h0000, 0,  1,0,16'h0080,16'hFFFF,1, 0,0,0);
      av(1, 1,1,16'h0080, 0,0,0,16'h0000,16'h0000, 0,  1,0,16'h0080,16'hFFFF,1, 0,0,0);
      av(0, 0,0,16'h0000, 0,0,0,16'h0000,16'h0000, 1,  0,0,16'h0000,16'h0000,0, 0,0,0);
      av(0, 0,0,16'h0000, 0,0,0,16'h0000,16'h0000, 0,  0,0,16'h0000,16'h0000,0, 0,0,0);
      // dmem flush mid-grant: bus held to mem_ack, ack suppressed
      av(0, 0,0,16'h0000, 1,1,0,16'h3000,16'h00FF, 0,  0,0,16'h0000,16'h0000,0, 0,0,0);
      av(0, 0,0,16'h0000, 1,1,0,16'h3000,16'h00FF, 0,  1,0,16'h3000,16'h00FF,2, 0,0,1);
      av(0, 0,0,16'h0000, 1,0,0,16'h3000,16'h00FF, 0,  1,0,16'h3000,16'h00FF,2, 0,0,1);
      av(0, 0,0,16'h0000, 1,0,0,16'h3000,16'h00FF, 1,  1,0,16'h3000,16'h00FF,2, 0,0,1);
      av(0, 0,0,16'h0000, 0,0,0,16'h3000,16'h00FF, 0,  0,0,16'h0000,16'h0000,0, 0,0,0);

      do_reset();
      check("reset mem_stb", 128'(mem_stb), 128'(0));
      check("reset grant_d", 128'(grant_d), 128'(0));

      foreach (vecs[i]) begin
         rst = vecs[i].rst;
         imem_stb = vecs[i].is; imem_cyc = vecs[i].ic; imem_addr = vecs[i].ia;
         dmem_stb = vecs[i].ds; dmem_cyc = vecs[i].dc; dmem_we = vecs[i].dw;
         dmem_addr = vecs[i].da; dmem_sel = vecs[i].dsel; mem_ack = vecs[i].ack;
         @(negedge clk);
         wd_exp = (vecs[i].e_wd == 2'd1) ? IW : (vecs[i].e_wd == 2'd2) ? DW : '0;
         check($sformatf("v%0d mem_stb", i),   128'(mem_stb),   128'(vecs[i].e_stb));
         check($sformatf("v%0d mem_cyc", i),   128'(mem_cyc),   128'(vecs[i].e_stb));
         check($sformatf("v%0d mem_we", i),    128'(mem_we),    128'(vecs[i].e_we));
         check($sformatf("v%0d mem_addr", i),  128'(mem_addr),  128'(vecs[i].e_addr));
         check($sformatf("v%0d mem_sel", i),   128'(mem_sel),   128'(vecs[i].e_sel));
         check($sformatf("v%0d mem_wdata", i), mem_wdata,       wd_exp);
         check($sformatf("v%0d imem_ack", i),  128'(imem_ack),  128'(vecs[i].e_iack));
         check($sformatf("v%0d dmem_ack", i),  128'(dmem_ack),  128'(vecs[i].e_dack));
         check($sformatf("v%0d grant_d", i),   128'(grant_d),   128'(vecs[i].e_gd));
         @(posedge clk);
         #1;
      end

      // Four arbitration rounds with both sides continuously pending.
      do_reset();
      imem_stb = 1'b1; imem_cyc = 1'b1; imem_addr = 16'h0040;
      dmem_stb = 1'b1; dmem_cyc = 1'b1; dmem_we = 1'b0;
      dmem_addr = 16'h2000; dmem_sel = 16'hFFFF;
      for (int r = 0; r < 4; r++) begin
`ifdef ARB_RR_EN
         exp_d = (r % 2 == 0);
`else
         exp_d = 1'b1;
`endif
         @(negedge clk);
         check($sformatf("rr%0d idle stb", r), 128'(mem_stb), 128'(0));
         @(posedge clk); #1;
         @(negedge clk);
         check($sformatf("rr%0d stb", r), 128'(mem_stb), 128'(1));
         check($sformatf("rr%0d grant_d", r), 128'(grant_d), 128'(exp_d));
         check($sformatf("rr%0d addr", r), 128'(mem_addr), exp_d ? 128'(16'h2000) : 128'(16'h0040));
         @(posedge clk); #1;
         mem_ack = 1'b1;
         @(negedge clk);
         check($sformatf("rr%0d imem_ack", r), 128'(imem_ack), 128'(!exp_d));
         check($sformatf("rr%0d dmem_ack", r), 128'(dmem_ack), 128'(exp_d));
         check($sformatf("rr%0d rdata", r), exp_d ? dmem_rdata : imem_rdata, RD);
         @(posedge clk); #1;
         mem_ack = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
